// File: rtl/marquee_scroller.sv
// Scrolling window over a loaded symbol message for a row of 7-seg digits.
// Wrap mode rotates circularly; bounce mode ping-pongs with a dwell at each end.
module marquee_scroller #(
  parameter int unsigned       NUM_DIGITS  = 4,
  parameter int unsigned       MSG_LEN     = 10,
  parameter int unsigned       SYM_W       = 4,
  parameter int unsigned       TICK_DIV    = 50_000_000,
  parameter int unsigned       DWELL_STEPS = 2,
  parameter logic [SYM_W-1:0]  BLANK_SYM   = 4'hF,
  localparam int unsigned      OFF_W       = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        load,
  input  logic [MSG_LEN*SYM_W-1:0]    msg_in,
  input  logic                        en,
  input  logic                        dir,
  input  logic                        bounce,
  output logic [NUM_DIGITS*SYM_W-1:0] digit_sym,
  output logic [OFF_W-1:0]            offset,
  output logic                        step_pulse,
  output logic                        busy
);

  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DW_W  = ($clog2(DWELL_STEPS + 1) > 0) ? $clog2(DWELL_STEPS + 1) : 1;

  localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(MSG_LEN - 1);
  localparam logic [OFF_W-1:0] MAX_OFF  = OFF_W'(MSG_LEN - NUM_DIGITS);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {EMPTY, RUN, DWELL} state_t;

  state_t                     state;
  logic [MSG_LEN*SYM_W-1:0]   msg;
  logic [PRE_W-1:0]           presc;
  logic [DW_W-1:0]            dwell;
  logic                       bdir;
  logic                       wrap_dir;
  logic                       mode_b;

  logic                       tick;
  logic [OFF_W-1:0]           wrap_next;
  logic [OFF_W-1:0]           b_next;
  logic                       b_end;
  logic [NUM_DIGITS*SYM_W-1:0] win;

  assign tick = en && (state != EMPTY) && (presc == PRE_LAST);
  assign busy = (state != EMPTY);

  always_comb begin
    wrap_next = '0;
    if (wrap_dir)
      wrap_next = (offset == '0) ? LAST_OFF : offset - 1'b1;
    else
      wrap_next = (offset == LAST_OFF) ? '0 : offset + 1'b1;
    b_next = bdir ? offset - 1'b1 : offset + 1'b1;
    b_end  = bdir ? (b_next == '0) : (b_next == MAX_OFF);
  end

  // Window index wraps at most once since offset < MSG_LEN and NUM_DIGITS <= MSG_LEN.
  always_comb begin
    int unsigned idx;
    win = '0;
    for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
      idx = 32'(offset) + d;
      if (idx >= MSG_LEN) idx = idx - MSG_LEN;
      win[d*SYM_W +: SYM_W] = msg[idx*SYM_W +: SYM_W];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= EMPTY;
      msg        <= {MSG_LEN{BLANK_SYM}};
      offset     <= '0;
      presc      <= '0;
      dwell      <= '0;
      bdir       <= 1'b0;
      wrap_dir   <= 1'b0;
      mode_b     <= 1'b0;
      digit_sym  <= {NUM_DIGITS{BLANK_SYM}};
      step_pulse <= 1'b0;
    end else begin
      digit_sym  <= win;
      step_pulse <= 1'b0;
      if (load) begin
        msg      <= msg_in;
        offset   <= '0;
        presc    <= '0;
        dwell    <= '0;
        bdir     <= 1'b0;
        wrap_dir <= dir;
        mode_b   <= bounce;
        state    <= RUN;
      end else if ((state != EMPTY) && en) begin
        presc <= (presc == PRE_LAST) ? '0 : presc + 1'b1;
        if (tick) begin
          case (state)
            RUN: begin
              if (!mode_b) begin
                offset     <= wrap_next;
                step_pulse <= (MSG_LEN > 1);
              end else if (MAX_OFF != '0) begin
                offset     <= b_next;
                step_pulse <= 1'b1;
                if (b_end) begin
                  bdir <= ~bdir;
                  if (DWELL_STEPS != 0) begin
                    dwell <= DW_W'(DWELL_STEPS);
                    state <= DWELL;
                  end
                end
              end
            end
            DWELL: begin
              dwell <= dwell - 1'b1;
              if (dwell == DW_W'(1)) state <= RUN;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_marquee_scroller.sv
// Bench for marquee_scroller: directed table on one instance plus random stimulus
// checked every cycle on three parameterisations against a tick-count reference model.
module tb_marquee_scroller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, load, en, dir, bounce;
  logic [39:0] msg_a;
  logic [23:0] msg_b;
  logic [11:0] msg_c;
  logic [15:0] dig_a, dig_b;
  logic [11:0] dig_c;
  logic [3:0]  off_a;
  logic [2:0]  off_b;
  logic [1:0]  off_c;
  logic        sp_a, sp_b, sp_c, busy_a, busy_b, busy_c;

  marquee_scroller #(.NUM_DIGITS(4), .MSG_LEN(10), .SYM_W(4), .TICK_DIV(3),
                     .DWELL_STEPS(2), .BLANK_SYM(4'hF)) u_a (
    .clk(clk), .rst_n(rst_n), .load(load), .msg_in(msg_a), .en(en), .dir(dir),
    .bounce(bounce), .digit_sym(dig_a), .offset(off_a), .step_pulse(sp_a), .busy(busy_a));

  marquee_scroller #(.NUM_DIGITS(4), .MSG_LEN(6), .SYM_W(4), .TICK_DIV(1),
                     .DWELL_STEPS(0), .BLANK_SYM(4'hF)) u_b (
    .clk(clk), .rst_n(rst_n), .load(load), .msg_in(msg_b), .en(en), .dir(dir),
    .bounce(bounce), .digit_sym(dig_b), .offset(off_b), .step_pulse(sp_b), .busy(busy_b));

  marquee_scroller #(.NUM_DIGITS(3), .MSG_LEN(3), .SYM_W(4), .TICK_DIV(2),
                     .DWELL_STEPS(1), .BLANK_SYM(4'hF)) u_c (
    .clk(clk), .rst_n(rst_n), .load(load), .msg_in(msg_c), .en(en), .dir(dir),
    .bounce(bounce), .digit_sym(dig_c), .offset(off_c), .step_pulse(sp_c), .busy(busy_c));

  localparam int unsigned ND[3] = '{4, 4, 3};
  localparam int unsigned ML[3] = '{10, 6, 3};
  localparam int unsigned TD[3] = '{3, 1, 2};
  localparam int unsigned DW[3] = '{2, 0, 1};

  logic [63:0] a_dig[3], a_off[3], a_msg[3];
  logic        a_sp[3], a_busy[3];
  assign a_dig[0] = 64'(dig_a);  assign a_dig[1] = 64'(dig_b);  assign a_dig[2] = 64'(dig_c);
  assign a_off[0] = 64'(off_a);  assign a_off[1] = 64'(off_b);  assign a_off[2] = 64'(off_c);
  assign a_msg[0] = 64'(msg_a);  assign a_msg[1] = 64'(msg_b);  assign a_msg[2] = 64'(msg_c);
  assign a_sp[0] = sp_a;     assign a_sp[1] = sp_b;     assign a_sp[2] = sp_c;
  assign a_busy[0] = busy_a; assign a_busy[1] = busy_b; assign a_busy[2] = busy_c;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Offset as a pure function of the number of scroll ticks since load.
  function automatic int unsigned bounce_pos(int unsigned m, int unsigned d, int unsigned t);
    int unsigned j;
    if (m == 0) return 0;
    j = t % (2*m + 2*d);
    if (j <= m) return j;
    if (j <= m + d) return m;
    if (j <= 2*m + d) return 2*m + d - j;
    return 0;
  endfunction

  function automatic int unsigned wrap_pos(int unsigned l, bit dn, int unsigned t);
    return dn ? (l - t % l) % l : t % l;
  endfunction

  logic [3:0]  m_msg[3][10];
  int unsigned m_off[3], m_enc[3];
  bit          m_loaded[3], m_dir[3], m_bnc[3], m_pulse[3];
  logic [63:0] m_dig[3];
  bit          m_valid = 1'b0;

  task automatic model_step(input int i);
    logic [63:0] nd;
    int unsigned old, t;
    nd = '0;
    for (int unsigned d = 0; d < ND[i]; d++)
      nd[d*4 +: 4] = m_msg[i][(m_off[i] + d) % ML[i]];
    old = m_off[i];
    if (!rst_n) begin
      for (int k = 0; k < 10; k++) m_msg[i][k] = 4'hF;
      m_dig[i] = '0;
      for (int unsigned d = 0; d < ND[i]; d++) m_dig[i][d*4 +: 4] = 4'hF;
      m_off[i] = 0; m_enc[i] = 0; m_loaded[i] = 1'b0; m_pulse[i] = 1'b0;
    end else begin
      m_dig[i] = nd;
      m_pulse[i] = 1'b0;
      if (load) begin
        for (int unsigned k = 0; k < ML[i]; k++) m_msg[i][k] = a_msg[i][k*4 +: 4];
        m_off[i] = 0; m_enc[i] = 0; m_loaded[i] = 1'b1;
        m_dir[i] = dir; m_bnc[i] = bounce;
      end else if (m_loaded[i] && en) begin
        m_enc[i]++;
        t = m_enc[i] / TD[i];
        m_off[i] = m_bnc[i] ? bounce_pos(ML[i] - ND[i], DW[i], t) : wrap_pos(ML[i], m_dir[i], t);
        m_pulse[i] = (m_off[i] != old);
      end
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) model_step(i);
    if (!rst_n) m_valid = 1'b1;
    #1;
    if (m_valid) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("model%0d.offset", i), a_off[i], 64'(m_off[i]));
        chk($sformatf("model%0d.digit_sym", i), a_dig[i], m_dig[i]);
        chk($sformatf("model%0d.step_pulse", i), 64'(a_sp[i]), 64'(m_pulse[i]));
        chk($sformatf("model%0d.busy", i), 64'(a_busy[i]), 64'(m_loaded[i]));
      end
    end
  end

  typedef struct {
    bit          rst_n, load, dir, bnc, en;
    int          ncyc;
    int          off;
    logic [15:0] dig;
    bit          pulse, busy;
    int          np;
  } row_t;

  row_t tbl[28];

  task automatic apply(input int r, input row_t v);
    int pc;
    pc = 0;
    @(negedge clk);
    rst_n = v.rst_n; load = v.load; dir = v.dir; bounce = v.bnc; en = v.en;
    repeat (v.ncyc) begin
      @(posedge clk); #1;
      if (sp_a) pc++;
    end
    chk($sformatf("row%0d.offset", r), 64'(off_a), 64'(v.off));
    chk($sformatf("row%0d.digit_sym", r), 64'(dig_a), 64'(v.dig));
    chk($sformatf("row%0d.step_pulse", r), 64'(sp_a), 64'(v.pulse));
    chk($sformatf("row%0d.busy", r), 64'(busy_a), 64'(v.busy));
    if (v.np >= 0) chk($sformatf("row%0d.pulse_count", r), 64'(pc), 64'(v.np));
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; en = 1'b0; dir = 1'b0; bounce = 1'b0;
    msg_a = 40'h98765_43210; msg_b = 24'h543210; msg_c = 12'h210;

    //            rst load dir bnc en ncyc off dig       pls busy np
    tbl[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,  2, 0, 16'hFFFF, 1'b0,1'b0, -1};
    tbl[1]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,100, 0, 16'hFFFF, 1'b0,1'b0,  0};
    tbl[2]  = '{1'b1,1'b1,1'b0,1'b0,1'b1,  1, 0, 16'hFFFF, 1'b0,1'b1, -1};
    tbl[3]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,  1, 0, 16'h3210, 1'b0,1'b1, -1};
    tbl[4]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,  2, 1, 16'h3210, 1'b1,1'b1,  1};
    tbl[5]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,  1, 1, 16'h4321, 1'b0,1'b1, -1};
    tbl[6]  = '{1'b1,1'b0,1'b0,1'b0,1'b1, 21, 8, 16'h1098, 1'b0,1'b1,  7};
    tbl[7]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,  6, 0, 16'h3210, 1'b0,1'b1,  2};
    tbl[8]  = '{1'b1,1'b1,1'b1,1'b0,1'b1,  1, 0, 16'h3210, 1'b0,1'b1, -1};
    tbl[9]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,  4, 9, 16'h2109, 1'b0,1'b1,  1};
    tbl[10] = '{1'b1,1'b0,1'b0,1'b0,1'b1,  3, 8, 16'h1098, 1'b0,1'b1,  1};
    tbl[11] = '{1'b1,1'b0,1'b0,1'b0,1'b1,  1, 8, 16'h1098, 1'b0,1'b1, -1};
    tbl[12] = '{1'b1,1'b0,1'b0,1'b0,1'b0, 20, 8, 16'h1098, 1'b0,1'b1,  0};
    tbl[13] = '{1'b1,1'b0,1'b0,1'b0,1'b1,  1, 7, 16'h1098, 1'b1,1'b1,  1};
    tbl[14] = '{1'b1,1'b0,1'b0,1'b0,1'b1,  1, 7, 16'h0987, 1'b0,1'b1, -1};
    tbl[15] = '{1'b1,1'b1,1'b0,1'b1,1'b1,  1, 0, 16'h0987, 1'b0,1'b1, -1};
    tbl[16] = '{1'b1,1'b0,1'b0,1'b0,1'b1, 19, 6, 16'h9876, 1'b0,1'b1,  6};
    tbl[17] = '{1'b1,1'b0,1'b0,1'b0,1'b1,  6, 6, 16'h9876, 1'b0,1'b1,  0};
    tbl[18] = '{1'b1,1'b0,1'b0,1'b0,1'b1,  3, 5, 16'h8765, 1'b0,1'b1,  1};
    tbl[19] = '{1'b1,1'b0,1'b0,1'b0,1'b1, 15, 0, 16'h3210, 1'b0,1'b1,  5};
    tbl[20] = '{1'b1,1'b0,1'b0,1'b0,1'b1,  6, 0, 16'h3210, 1'b0,1'b1,  0};
    tbl[21] = '{1'b1,1'b0,1'b0,1'b0,1'b1,  3, 1, 16'h4321, 1'b0,1'b1,  1};
    tbl[22] = '{1'b1,1'b0,1'b0,1'b0,1'b1, 48, 1, 16'h4321, 1'b0,1'b1, 12};
    tbl[23] = '{1'b1,1'b1,1'b0,1'b0,1'b1,  1, 0, 16'h4321, 1'b0,1'b1, -1};
    tbl[24] = '{1'b1,1'b0,1'b0,1'b0,1'b1, 17, 5, 16'h8765, 1'b0,1'b1,  5};
    tbl[25] = '{1'b1,1'b1,1'b0,1'b0,1'b1,  1, 0, 16'h8765, 1'b0,1'b1, -1};
    tbl[26] = '{1'b0,1'b1,1'b0,1'b0,1'b1,  1, 0, 16'hFFFF, 1'b0,1'b0, -1};
    tbl[27] = '{1'b1,1'b0,1'b0,1'b0,1'b1, 10, 0, 16'hFFFF, 1'b0,1'b0,  0};

    for (int r = 0; r < 28; r++) apply(r, tbl[r]);

    // Random phase: the per-cycle model checker does all the comparing here.
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      rst_n  = ($urandom_range(0, 399) != 0);
      load   = ($urandom_range(0, 89) == 0);
      en     = ($urandom_range(0, 9) < 8);
      dir    = $urandom_range(0, 1) != 0;
      bounce = $urandom_range(0, 1) != 0;
      msg_a  = {8'($urandom), 32'($urandom)};
      msg_b  = 24'($urandom);
      msg_c  = 12'($urandom);
    end
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
